mem_access_unit: RTL and testbench

- Sits between the MIPS execute/memory pipeline and the word-wide, big-endian, byte-addressed data memory.
- Executes LW/LH/LHU/LB/LBU/SW/SH/SB. Loads are extracted and extended; sub-word stores use read-modify-write, because the memory only reads and writes whole words with 1-cycle registered read latency.
- Reports misaligned accesses without touching memory.
- Holds the pipeline via `Busy` until `Done`.

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/byte_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM state encoding and per-op helper constants for mem_access_unit.
package mem_access_pkg;

  typedef enum logic [2:0] {
    OpLw  = 3'd0,
    OpLh  = 3'd1,
    OpLhu = 3'd2,
    OpLb  = 3'd3,
    OpLbu = 3'd4,
    OpSw  = 3'd5,
    OpSh  = 3'd6,
    OpSb  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StFormat = 3'd2,
    StMerge  = 3'd3,
    StWrite  = 3'd4,
    StDone   = 3'd5
  } state_e;

  // Bit n is set when op code n has the property; index with the op code.
  localparam logic [7:0] IS_LOAD    = 8'b0001_1111;
  localparam logic [7:0] IS_SUBWORD = 8'b1101_1110;

  // Words need offset 0; halfwords need an even offset; bytes are always aligned.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] offset);
    logic mis;
    case (op)
      OpLw, OpSw:        mis = |offset;
      OpLh, OpLhu, OpSh: mis = offset[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Big-endian byte-lane logic: load extract/extend and sub-word store merge.
module byte_lane_align
  import mem_access_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane(s), then extend for loads or splice for stores.
  always_comb begin
    byte_sel     = 8'h00;
    load_data_o  = rdata_i;
    merge_data_o = rdata_i;
    unique case (offset_i)
      2'd0: byte_sel = rdata_i[31:24];
      2'd1: byte_sel = rdata_i[23:16];
      2'd2: byte_sel = rdata_i[15:8];
      2'd3: byte_sel = rdata_i[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    case (op_i)
      OpLb:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   load_data_o = {24'h000000, byte_sel};
      OpLh:    load_data_o = {{16{half_sel[15]}}, half_sel};
      OpLhu:   load_data_o = {16'h0000, half_sel};
      default: load_data_o = rdata_i;
    endcase

    if (op_i == OpSb) begin
      unique case (offset_i)
        2'd0: merge_data_o[31:24] = store_data_i[7:0];
        2'd1: merge_data_o[23:16] = store_data_i[7:0];
        2'd2: merge_data_o[15:8]  = store_data_i[7:0];
        2'd3: merge_data_o[7:0]   = store_data_i[7:0];
        default: merge_data_o = rdata_i;
      endcase
    end else if (op_i == OpSh) begin
      if (offset_i[1]) merge_data_o[15:0]  = store_data_i;
      else             merge_data_o[31:16] = store_data_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS load/store unit: sequences word-only memory accesses, read-modify-write for
// sub-word stores, and flags misaligned requests without touching memory.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clock,
  input  logic                 ResetN,
  input  logic                 Start,
  input  logic [2:0]           Op,
  input  logic [AddrWidth-1:0] Address,
  input  logic [DataWidth-1:0] StoreData,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [DataWidth-1:0] LoadData,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [AddrWidth-1:0] MemAddress,
  output logic [DataWidth-1:0] MemWriteData,
  input  logic [DataWidth-1:0] MemReadData
);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [DataWidth-1:0]   load_data_q, load_data_d;
  logic [31:0]            aligned_load;
  logic [31:0]            merged_word;

  byte_lane_align u_align (
    .op_i         (op_q),
    .offset_i     (addr_q[1:0]),
    .rdata_i      (MemReadData),
    .store_data_i (wdata_q[15:0]),
    .load_data_o  (aligned_load),
    .merge_data_o (merged_word)
  );

  // Next-state logic; requests are latched only on the IDLE accept edge.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          op_d    = op_e'(Op);
          addr_d  = Address;
          wdata_d = StoreData;
          err_d   = is_misaligned(op_e'(Op), Address[1:0]);
          if (err_d)                                state_d = StDone;
          else if (IS_LOAD[Op] || IS_SUBWORD[Op])   state_d = StRead;
          else                                      state_d = StWrite;
        end
      end
      StRead:   state_d = IS_LOAD[op_q] ? StFormat : StMerge;
      StFormat: begin
        load_data_d = aligned_load;
        state_d     = StDone;
      end
      StMerge:  state_d = StDone;
      StWrite:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and request registers; async reset drops any in-flight request.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= StIdle;
      op_q        <= OpLw;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  // Outputs decode from state so reset kills MemWrite in the same cycle.
  always_comb begin
    Busy         = (state_q != StIdle);
    Done         = (state_q == StDone);
    Error        = Done && err_q;
    MemRead      = (state_q == StRead);
    MemWrite     = (state_q == StMerge) || (state_q == StWrite);
    MemAddress   = {addr_q[AddrWidth-1:2], 2'b00};
    LoadData     = load_data_q;
    MemWriteData = '0;
    if (state_q == StMerge)      MemWriteData = merged_word;
    else if (state_q == StWrite) MemWriteData = wdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 1-cycle registered word memory model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] Address = '0;
  logic [31:0] StoreData = '0;
  logic        Busy, Done, Error, MemRead, MemWrite;
  logic [31:0] LoadData, MemAddress, MemWriteData;
  logic [31:0] MemReadData = '0;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

  mem_access_unit #(.AddrWidth(32), .DataWidth(32)) dut (
    .clock        (clock),
    .ResetN       (ResetN),
    .Start        (Start),
    .Op           (Op),
    .Address      (Address),
    .StoreData    (StoreData),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error),
    .LoadData     (LoadData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemReadData  (MemReadData)
  );

  always #5 clock = ~clock;

  // Word memory: registered read, write on the edge where MemWrite is high.
  logic [31:0] mem [0:15];
  always @(posedge clock) begin
    if (MemRead)  MemReadData <= mem[MemAddress[5:2]];
    if (MemWrite) mem[MemAddress[5:2]] <= MemWriteData;
  end

  typedef struct {
    string       name;
    logic [31:0] load;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, tracks per-transaction cycle counts.
  int cyc = 0, nrd = 0, nwr = 0;
  logic prev_busy = 1'b0;
  always @(negedge clock) begin
    if (!ResetN) begin
      prev_busy = 1'b0;
    end else begin
      if (Busy) begin
        if (!prev_busy) begin
          cyc = 1; nrd = 0; nwr = 0;
        end else begin
          cyc++;
        end
        if (MemRead) nrd++;
        if (MemWrite) begin
          nwr++;
          if (wr_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            check("write_addr", MemAddress, w.addr);
            check("write_data", MemWriteData, w.data);
          end
        end
        if (Done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_latency"}, 32'(cyc), 32'(e.lat));
            check({e.name, "_error"}, {31'd0, Error}, {31'd0, e.err});
            check({e.name, "_loaddata"}, LoadData, e.load);
            check({e.name, "_reads"}, 32'(nrd), 32'(e.nrd));
            check({e.name, "_writes"}, 32'(nwr), 32'(e.nwr));
          end
        end else begin
          check("error_outside_done", {31'd0, Error}, 32'd0);
        end
      end else begin
        check("idle_quiet", {28'd0, Done, Error, MemRead, MemWrite}, 32'd0);
      end
      prev_busy = Busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (Busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (Busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    Op = op; Address = a; StoreData = d; Start = 1'b1;
    @(posedge clock);
    #1 Start = 1'b0;
  endtask

  task automatic push_exp(input string name, input logic [31:0] load, input logic err,
                          input int lat, input int r, input int w);
    exp_t e;
    e.name = name; e.load = load; e.err = err; e.lat = lat; e.nrd = r; e.nwr = w;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] load, input logic err,
                       input int lat, input int r, input int w);
    push_exp(name, load, err, lat, r, w);
    start_req(op, a, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    check({tag, "_done"}, {31'd0, Done}, 32'd0);
    check({tag, "_error"}, {31'd0, Error}, 32'd0);
    check({tag, "_memread"}, {31'd0, MemRead}, 32'd0);
    check({tag, "_memwrite"}, {31'd0, MemWrite}, 32'd0);
    check({tag, "_loaddata"}, LoadData, 32'd0);
    check({tag, "_memaddress"}, MemAddress, 32'd0);
    check({tag, "_memwritedata"}, MemWriteData, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h807F1234;

    repeat (2) @(posedge clock);
    #1 check_reset_outputs("reset");
    @(posedge clock);
    #3 ResetN = 1'b1;

    // Loads from word 0x807F1234
    issue("lw_10",  LW,  32'h10, 32'h0, 32'h807F1234, 1'b0, 3, 1, 0);
    issue("lb_10",  LB,  32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1, 0);
    issue("lbu_10", LBU, 32'h10, 32'h0, 32'h00000080, 1'b0, 3, 1, 0);
    issue("lh_10",  LH,  32'h10, 32'h0, 32'hFFFF807F, 1'b0, 3, 1, 0);
    issue("lhu_12", LHU, 32'h12, 32'h0, 32'h00001234, 1'b0, 3, 1, 0);
    issue("lb_13",  LB,  32'h13, 32'h0, 32'h00000034, 1'b0, 3, 1, 0);
    issue("lb_11",  LB,  32'h11, 32'h0, 32'h0000007F, 1'b0, 3, 1, 0);
    issue("lh_12",  LH,  32'h12, 32'h0, 32'h00001234, 1'b0, 3, 1, 0);
    issue("lb_12",  LB,  32'h12, 32'h0, 32'h00000012, 1'b0, 3, 1, 0);

    // Misaligned: no memory traffic, LoadData keeps the last load
    issue("lw_12_mis", LW, 32'h12, 32'h0,    32'h00000012, 1'b1, 1, 0, 0);
    issue("sh_13_mis", SH, 32'h13, 32'hBEEF, 32'h00000012, 1'b1, 1, 0, 0);
    issue("lw_10_post_mis", LW, 32'h10, 32'h0, 32'h807F1234, 1'b0, 3, 1, 0);

    // SH 0x10 aborted by reset during MERGE
    start_req(SH, 32'h10, 32'h0000BEEF);
    @(posedge clock);
    #1;
    check("abort_in_merge", {31'd0, MemWrite}, 32'd1);
    check("abort_merge_data", MemWriteData, 32'hBEEF1234);
    ResetN = 1'b0;
    #1 check_reset_outputs("midop_reset");
    @(posedge clock);
    #3 ResetN = 1'b1;
    issue("lw_10_after_abort", LW, 32'h10, 32'h0, 32'h807F1234, 1'b0, 3, 1, 0);

    // Sub-word and word stores
    push_wr(32'h10, 32'h80AA1234);
    issue("sb_11", SB, 32'h11, 32'h000000AA, 32'h807F1234, 1'b0, 3, 1, 1);
    issue("lw_10_after_sb", LW, 32'h10, 32'h0, 32'h80AA1234, 1'b0, 3, 1, 0);
    push_wr(32'h14, 32'hDEADBEEF);
    issue("sw_14", SW, 32'h14, 32'hDEADBEEF, 32'h80AA1234, 1'b0, 2, 0, 1);
    push_wr(32'h14, 32'hDEADCAFE);
    issue("sh_16", SH, 32'h16, 32'h0000CAFE, 32'h80AA1234, 1'b0, 3, 1, 1);
    push_wr(32'h14, 32'h77ADCAFE);
    issue("sb_14", SB, 32'h14, 32'h12345677, 32'h80AA1234, 1'b0, 3, 1, 1);
    issue("lh_16", LH, 32'h16, 32'h0, 32'hFFFFCAFE, 1'b0, 3, 1, 0);
    issue("lw_14", LW, 32'h14, 32'h0, 32'h77ADCAFE, 1'b0, 3, 1, 0);
    issue("sw_15_mis", SW, 32'h15, 32'h11111111, 32'h77ADCAFE, 1'b1, 1, 0, 0);

    // Start held high: second request waits for the IDLE cycle after Done
    push_exp("held_lw", 32'h80AA1234, 1'b0, 3, 1, 0);
    wait_idle();
    Op = LW; Address = 32'h10; StoreData = 32'h0; Start = 1'b1;
    @(posedge clock);
    #1;
    push_exp("held_sb", 32'h80AA1234, 1'b0, 3, 1, 1);
    push_wr(32'h10, 32'h80551234);
    Op = SB; Address = 32'h11; StoreData = 32'h00000055;
    wait_idle();
    @(posedge clock);
    #1 Start = 1'b0;
    @(negedge clock);
    check("held_second_accept", {31'd0, Busy}, 32'd1);
    issue("lw_10_after_held", LW, 32'h10, 32'h0, 32'h80551234, 1'b0, 3, 1, 0);

    // Drain
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(negedge clock);
        n++;
      end
    end
    repeat (3) @(negedge clock);
    check("pending_done", 32'(exp_q.size()), 32'd0);
    check("pending_writes", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
